// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: 640x480@60 timing constants, sync-window bounds, raster types and a window-decode helper
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_LO = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_HI = VGA_HS_LO + VGA_H_SYNC - 1;
  localparam int VGA_VS_LO = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_HI = VGA_VS_LO + VGA_V_SYNC - 1;
  localparam int CNT_W = 10;
  localparam int ADDR_W = 19;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  function automatic logic in_win(cnt_t x, cnt_t lo, cnt_t hi);
    return x >= lo && x <= hi;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bus (pixel_tick, H/V counts, syncs, video_on, frame_start, pixel_addr); master drives, slave consumes
interface vga_timing_gen_if;
  import vga_pkg::*;
  logic pixel_tick;
  cnt_t H_Count_Value;
  cnt_t V_Count_Value;
  logic hsync;
  logic vsync;
  logic video_on;
  logic frame_start;
  addr_t pixel_addr;
  modport master(output pixel_tick, H_Count_Value, V_Count_Value, hsync, vsync, video_on, frame_start, pixel_addr);
  modport slave(input pixel_tick, H_Count_Value, V_Count_Value, hsync, vsync, video_on, frame_start, pixel_addr);
endinterface

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// pix_tick_gen: clock-enable divider; o_tick is high on the last clk of every CLK_DIV-clk period, low in reset
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] r_div;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_div <= '0;
    else r_div <= r_div == LAST ? '0 : r_div + DW'(1);
  assign o_tick = rst_n && r_div == LAST;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster generator; ports clk, rst_n (async active-low) and master raster bus o_vga, all outputs but pixel_tick registered from the next position
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  vga_timing_gen_if.master o_vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;
  logic w_tick;
  cnt_t r_h, r_v;
  logic r_hs, r_vs, r_von, r_fs;
  addr_t r_addr;
  cnt_t w_h_nx, w_v_nx;
  logic w_h_wrap, w_zero, w_act;
  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .o_tick(w_tick));
  always_comb begin
    w_h_wrap = r_h == cnt_t'(H_TOTAL - 1);
    w_h_nx = w_h_wrap ? '0 : r_h + cnt_t'(1);
    w_v_nx = !w_h_wrap ? r_v : r_v == cnt_t'(V_TOTAL - 1) ? '0 : r_v + cnt_t'(1);
    w_zero = w_h_nx == '0 && w_v_nx == '0;
    w_act = w_h_nx < cnt_t'(H_ACTIVE) && w_v_nx < cnt_t'(V_ACTIVE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_h <= cnt_t'(H_TOTAL - 1);
      r_v <= cnt_t'(V_TOTAL - 1);
      r_hs <= !SYNC_POL;
      r_vs <= !SYNC_POL;
      r_von <= 1'b0;
      r_fs <= 1'b0;
      r_addr <= '0;
    end else begin
      r_fs <= w_tick && w_zero;
      if (w_tick) begin
        r_h <= w_h_nx;
        r_v <= w_v_nx;
        r_hs <= in_win(w_h_nx, cnt_t'(HS_LO), cnt_t'(HS_HI)) ? SYNC_POL : !SYNC_POL;
        r_vs <= in_win(w_v_nx, cnt_t'(VS_LO), cnt_t'(VS_HI)) ? SYNC_POL : !SYNC_POL;
        r_von <= w_act;
        r_addr <= w_zero ? '0 : w_act ? r_addr + addr_t'(1) : r_addr;
      end
    end
  assign o_vga.pixel_tick = w_tick;
  assign o_vga.H_Count_Value = r_h;
  assign o_vga.V_Count_Value = r_v;
  assign o_vga.hsync = r_hs;
  assign o_vga.vsync = r_vs;
  assign o_vga.video_on = r_von;
  assign o_vga.frame_start = r_fs;
  assign o_vga.pixel_addr = r_addr;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen at full 640x480 timing and at a reduced raster for frame-level behaviour
module tb_vga_timing_gen;
  typedef struct packed {
    logic tick;
    logic [9:0] h;
    logic [9:0] v;
    logic hs;
    logic vs;
    logic von;
    logic fs;
    logic [18:0] addr;
  } obs_t;
  typedef struct {
    int cd, ha, hf, hs, hb, va, vf, vs, vb;
  } geo_t;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  int checks = 0;
  int errors = 0;
  obs_t sb[$];
  obs_t got0, got1, got2;
  geo_t g0 = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
  geo_t g1 = '{2, 8, 2, 3, 3, 6, 2, 2, 2};
  geo_t g2 = '{1, 8, 2, 3, 3, 6, 2, 2, 2};
  obs_t rst_big = '{tick: 1'b0, h: 10'd799, v: 10'd524, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, addr: 19'd0};
  obs_t rst_small = '{tick: 1'b0, h: 10'd15, v: 10'd11, hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, addr: 19'd0};
  vga_timing_gen_if vif0();
  vga_timing_gen_if vif1();
  vga_timing_gen_if vif2();
  vga_timing_gen dut0 (.clk(clk), .rst_n(rst0_n), .o_vga(vif0));
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut1 (.clk(clk), .rst_n(rst1_n), .o_vga(vif1));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut2 (.clk(clk), .rst_n(rst2_n), .o_vga(vif2));
  assign got0 = {vif0.pixel_tick, vif0.H_Count_Value, vif0.V_Count_Value, vif0.hsync, vif0.vsync, vif0.video_on, vif0.frame_start, vif0.pixel_addr};
  assign got1 = {vif1.pixel_tick, vif1.H_Count_Value, vif1.V_Count_Value, vif1.hsync, vif1.vsync, vif1.video_on, vif1.frame_start, vif1.pixel_addr};
  assign got2 = {vif2.pixel_tick, vif2.H_Count_Value, vif2.V_Count_Value, vif2.hsync, vif2.vsync, vif2.video_on, vif2.frame_start, vif2.pixel_addr};
  always #5 clk = ~clk;

  function automatic obs_t model(int e, geo_t g);
    obs_t o;
    int ht, vt, k, p, h, v;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    k = e / g.cd;
    o.tick = (e % g.cd) == g.cd - 1;
    if (k == 0) begin
      o.h = 10'(ht - 1);
      o.v = 10'(vt - 1);
      o.hs = 1'b1;
      o.vs = 1'b1;
      o.von = 1'b0;
      o.fs = 1'b0;
      o.addr = '0;
      return o;
    end
    p = (k - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    o.h = 10'(h);
    o.v = 10'(v);
    o.hs = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
    o.vs = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
    o.von = h < g.ha && v < g.va;
    o.fs = p == 0 && (e % g.cd) == 0;
    o.addr = 19'(v >= g.va ? g.ha * g.va - 1 : h >= g.ha ? v * g.ha + g.ha - 1 : v * g.ha + h);
    return o;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got0 !== rst_big) begin errors++; $display("FAIL reset_state got=%h exp=%h", got0, rst_big); end
    checks++;
    if ({got0.h, got0.v} !== {10'd799, 10'd524}) begin errors++; $display("FAIL reset_hv got=%0d,%0d exp=799,524", got0.h, got0.v); end
    checks++;
    if ({got0.hs, got0.vs, got0.von, got0.addr} !== {1'b1, 1'b1, 1'b0, 19'd0}) begin errors++; $display("FAIL reset_sync got=%b%b%b addr=%0d exp=110 addr=0", got0.hs, got0.vs, got0.von, got0.addr); end
    checks++;
    if (got0.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", got0.tick); end
  endtask

  task automatic test_full_line();
    obs_t exp;
    @(negedge clk);
    rst0_n = 1'b1;
    for (int e = 1; e <= 3204; e++) begin
      sb.push_back(model(e, g0));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (got0 !== exp) begin errors++; $display("FAIL line e=%0d got=%h exp=%h", e, got0, exp); end
      if (e == 1) begin
        checks++;
        if ({got0.tick, got0.h, got0.fs} !== {1'b1, 10'd799, 1'b0}) begin errors++; $display("FAIL first_tick got=%b h=%0d fs=%b exp=1 h=799 fs=0", got0.tick, got0.h, got0.fs); end
      end
      if (e == 2) begin
        checks++;
        if ({got0.h, got0.v, got0.fs, got0.von, got0.addr} !== {10'd0, 10'd0, 1'b1, 1'b1, 19'd0}) begin errors++; $display("FAIL origin got=%h exp=(0,0) fs=1 von=1 addr=0", got0); end
      end
      if (e == 1280) begin
        checks++;
        if ({got0.h, got0.v, got0.addr} !== {10'd639, 10'd0, 19'd639}) begin errors++; $display("FAIL addr_639_0 got=%0d,%0d addr=%0d exp=639,0 addr=639", got0.h, got0.v, got0.addr); end
      end
      if (e == 1282) begin
        checks++;
        if ({got0.h, got0.von, got0.addr} !== {10'd640, 1'b0, 19'd639}) begin errors++; $display("FAIL von_640 got=h%0d von=%b addr=%0d exp=h640 von=0 addr=639", got0.h, got0.von, got0.addr); end
      end
      if (e == 1312 || e == 1506) begin
        checks++;
        if (got0.hs !== 1'b1) begin errors++; $display("FAIL hsync_edge_off e=%0d h=%0d got=%b exp=1", e, got0.h, got0.hs); end
      end
      if (e == 1314 || e == 1504) begin
        checks++;
        if (got0.hs !== 1'b0) begin errors++; $display("FAIL hsync_edge_on e=%0d h=%0d got=%b exp=0", e, got0.h, got0.hs); end
      end
      if (e == 1602) begin
        checks++;
        if ({got0.h, got0.v, got0.addr} !== {10'd0, 10'd1, 19'd640}) begin errors++; $display("FAIL addr_0_1 got=%0d,%0d addr=%0d exp=0,1 addr=640", got0.h, got0.v, got0.addr); end
      end
    end
  endtask

  task automatic test_frame();
    obs_t exp;
    @(negedge clk);
    rst1_n = 1'b1;
    for (int e = 1; e <= 904; e++) begin
      sb.push_back(model(e, g1));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (got1 !== exp) begin errors++; $display("FAIL frame e=%0d got=%h exp=%h", e, got1, exp); end
      if (e == 176) begin
        checks++;
        if ({got1.h, got1.v, got1.addr} !== {10'd7, 10'd5, 19'd47}) begin errors++; $display("FAIL addr_max got=%0d,%0d addr=%0d exp=7,5 addr=47", got1.h, got1.v, got1.addr); end
      end
      if (e == 300) begin
        checks++;
        if ({got1.von, got1.addr} !== {1'b0, 19'd47}) begin errors++; $display("FAIL addr_hold got=von%b addr=%0d exp=von0 addr=47", got1.von, got1.addr); end
      end
      if (e == 256 || e == 322) begin
        checks++;
        if (got1.vs !== 1'b1) begin errors++; $display("FAIL vsync_off e=%0d v=%0d got=%b exp=1", e, got1.v, got1.vs); end
      end
      if (e == 258 || e == 320) begin
        checks++;
        if (got1.vs !== 1'b0) begin errors++; $display("FAIL vsync_on e=%0d v=%0d got=%b exp=0", e, got1.v, got1.vs); end
      end
      if (e == 386) begin
        checks++;
        if ({got1.h, got1.v, got1.fs, got1.addr} !== {10'd0, 10'd0, 1'b1, 19'd0}) begin errors++; $display("FAIL frame_wrap got=%h exp=(0,0) fs=1 addr=0", got1); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    obs_t exp;
    checks++;
    if ({got1.h, got1.v} !== {10'd3, 10'd4}) begin errors++; $display("FAIL pre_pulse_pos got=%0d,%0d exp=3,4", got1.h, got1.v); end
    #2;
    rst1_n = 1'b0;
    #1;
    checks++;
    if (got1 !== rst_small) begin errors++; $display("FAIL async_reset got=%h exp=%h", got1, rst_small); end
    @(posedge clk);
    #1;
    checks++;
    if (got1 !== rst_small) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got1, rst_small); end
    @(negedge clk);
    rst1_n = 1'b1;
    for (int e = 1; e <= 388; e++) begin
      sb.push_back(model(e, g1));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (got1 !== exp) begin errors++; $display("FAIL restart e=%0d got=%h exp=%h", e, got1, exp); end
      if (e == 2) begin
        checks++;
        if ({got1.h, got1.v, got1.fs, got1.addr} !== {10'd0, 10'd0, 1'b1, 19'd0}) begin errors++; $display("FAIL restart_origin got=%h exp=(0,0) fs=1 addr=0", got1); end
      end
    end
  endtask

  task automatic test_clk_div1();
    obs_t exp;
    int fs_first = -1;
    int fs_second = -1;
    int ticks = 0;
    checks++;
    if (got2.tick !== 1'b0) begin errors++; $display("FAIL div1_reset_tick got=%b exp=0", got2.tick); end
    @(negedge clk);
    rst2_n = 1'b1;
    for (int e = 1; e <= 386; e++) begin
      sb.push_back(model(e, g2));
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      checks++;
      if (got2 !== exp) begin errors++; $display("FAIL div1 e=%0d got=%h exp=%h", e, got2, exp); end
      ticks += int'(got2.tick);
      if (got2.fs === 1'b1) begin
        if (fs_first < 0) fs_first = e;
        else if (fs_second < 0) fs_second = e;
      end
    end
    checks++;
    if (ticks !== 386) begin errors++; $display("FAIL div1_tick_const got=%0d exp=386", ticks); end
    checks++;
    if (fs_first !== 1) begin errors++; $display("FAIL div1_first_fs got=%0d exp=1", fs_first); end
    checks++;
    if (fs_second - fs_first !== 192) begin errors++; $display("FAIL div1_fs_period got=%0d exp=192", fs_second - fs_first); end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_frame();
    test_reset_midframe();
    test_clk_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
